// File: rtl/bcd_seg_scan.sv
// Multiplexed 6-digit 7-segment driver for packed BCD.
// Snapshots num/dp once per frame and decodes one digit per slot.
module bcd_seg_scan #(
  parameter logic [31:0] SCAN_DIV    = 32'd50_000,
  parameter logic        BLANK_LZ    = 1'b1,
  parameter logic        SEG_ACT_LOW = 1'b1,
  parameter logic        SEL_ACT_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] num,
  input  logic [5:0]  dp,
  output logic [5:0]  sel,
  output logic [7:0]  seg,
  output logic        frame_start
);

  typedef enum logic {IDLE, SCAN} state_e;

  localparam logic [5:0] SEL_OFF = SEL_ACT_LOW ? 6'h3F : 6'h00;
  localparam logic [7:0] SEG_OFF = SEG_ACT_LOW ? 8'hFF : 8'h00;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [23:0] num_q, num_d;
  logic [5:0]  dp_q, dp_d;
  logic [5:0]  sel_q, sel_d;
  logic [7:0]  seg_q, seg_d;
  logic        fs_q, fs_d;
  logic        tick;
  logic        load;
  logic [5:0]  lz;
  logic [3:0]  dig;
  logic [6:0]  dec;
  logic [7:0]  seg_hi;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] r;
    case (d)
      4'd0:    r = 7'h3F;
      4'd1:    r = 7'h06;
      4'd2:    r = 7'h5B;
      4'd3:    r = 7'h4F;
      4'd4:    r = 7'h66;
      4'd5:    r = 7'h6D;
      4'd6:    r = 7'h7D;
      4'd7:    r = 7'h07;
      4'd8:    r = 7'h7F;
      4'd9:    r = 7'h6F;
      default: r = 7'h40;
    endcase
    return r;
  endfunction

  assign tick = (cnt_q == SCAN_DIV - 32'd1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    num_d   = num_q;
    dp_d    = dp_q;
    load    = 1'b0;
    cnt_d   = tick ? 32'd0 : cnt_q + 32'd1;
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          load    = 1'b1;
          idx_d   = 3'd0;
          state_d = SCAN;
        end
        SCAN: begin
          if (idx_q == 3'd5) begin
            load  = 1'b1;
            idx_d = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (load) begin
      num_d = num;
      dp_d  = dp;
    end
  end

  // lz[k]: digits k..5 of the new snapshot are all zero
  always_comb begin
    lz    = 6'd0;
    lz[5] = (num_d[23:20] == 4'h0);
    for (int k = 4; k >= 0; k--) begin
      lz[k] = lz[k+1] & (num_d[4*k +: 4] == 4'h0);
    end
  end

  always_comb begin
    sel_d  = sel_q;
    seg_d  = seg_q;
    fs_d   = 1'b0;
    dig    = num_d[4*idx_d +: 4];
    dec    = decode(dig);
    seg_hi = {dp_d[idx_d], dec};
    if (BLANK_LZ && (idx_d != 3'd0) && lz[idx_d]) begin
      seg_hi = 8'h00;
    end
    if (tick) begin
      fs_d  = load;
      sel_d = (6'd1 << idx_d) ^ SEL_OFF;
      seg_d = seg_hi ^ SEG_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 32'd0;
      idx_q   <= 3'd0;
      num_q   <= 24'd0;
      dp_q    <= 6'd0;
      sel_q   <= SEL_OFF;
      seg_q   <= SEG_OFF;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      dp_q    <= dp_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
      fs_q    <= fs_d;
    end
  end

  assign sel         = sel_q;
  assign seg         = seg_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Directed bench for bcd_seg_scan: two instances, blanking on and off.
// Expected segment codes are hand-decoded constants.
module tb_bcd_seg_scan;

  logic        clk;
  logic        rst;
  logic [23:0] num;
  logic [5:0]  dp;
  logic [5:0]  sel0, sel1;
  logic [7:0]  seg0, seg1;
  logic        fs0, fs1;

  int vec_cnt;
  int err_cnt;

  bcd_seg_scan #(
    .SCAN_DIV(32'd4),
    .BLANK_LZ(1'b1)
  ) u_dut0 (
    .clk(clk),
    .rst(rst),
    .num(num),
    .dp(dp),
    .sel(sel0),
    .seg(seg0),
    .frame_start(fs0)
  );

  bcd_seg_scan #(
    .SCAN_DIV(32'd4),
    .BLANK_LZ(1'b0)
  ) u_dut1 (
    .clk(clk),
    .rst(rst),
    .num(num),
    .dp(dp),
    .sel(sel1),
    .seg(seg1),
    .frame_start(fs1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle3();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("idle%0d_sel", i), 32'(sel0), 32'h3F);
      chk($sformatf("idle%0d_seg", i), 32'(seg0), 32'hFF);
      chk($sformatf("idle%0d_fs", i), 32'(fs0), 32'h0);
    end
  endtask

  // e[8k+:8] is the expected seg code of digit k
  task automatic run_frame(input int first, input int nslots,
                           input logic [47:0] e0, input logic [47:0] e1,
                           input int chg_at, input logic [23:0] chg_num);
    logic [5:0] es;
    for (int k = 0; k < nslots; k++) begin
      repeat ((k == 0) ? first : 4) @(posedge clk);
      @(negedge clk);
      es = ~(6'd1 << k) & 6'h3F;
      chk($sformatf("d%0d_sel0", k), 32'(sel0), 32'(es));
      chk($sformatf("d%0d_sel1", k), 32'(sel1), 32'(es));
      chk($sformatf("d%0d_seg0", k), 32'(seg0), 32'(e0[8*k +: 8]));
      chk($sformatf("d%0d_seg1", k), 32'(seg1), 32'(e1[8*k +: 8]));
      chk($sformatf("d%0d_fs", k), 32'(fs0), (k == 0) ? 32'h1 : 32'h0);
      if (k == chg_at) num = chg_num;
    end
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst = 1'b1;
    num = 24'h000060;
    dp  = 6'b000000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_sel", 32'(sel0), 32'h3F);
    chk("rst_seg", 32'(seg0), 32'hFF);
    chk("rst_fs", 32'(fs0), 32'h0);
    rst = 1'b0;

    idle3();
    run_frame(1, 6, 48'hFFFF_FFFF_82C0, 48'hC0C0_C0C0_82C0, 9, 24'h0);

    num = 24'h123456;
    run_frame(4, 6, 48'hF9A4_B099_9282, 48'hF9A4_B099_9282, 1, 24'h999999);

    run_frame(4, 6, 48'h9090_9090_9090, 48'h9090_9090_9090, 0, 24'h000000);

    run_frame(4, 6, 48'hFFFF_FFFF_FFC0, 48'hC0C0_C0C0_C0C0, 9, 24'h0);

    num = 24'h00A005;
    run_frame(4, 6, 48'hFFFF_BFC0_C092, 48'hC0C0_BFC0_C092, 9, 24'h0);

    num = 24'h000012;
    dp  = 6'b000010;
    run_frame(4, 6, 48'hFFFF_FFFF_79A4, 48'hC0C0_C0C0_79A4, 9, 24'h0);

    run_frame(4, 4, 48'hFFFF_FFFF_79A4, 48'hC0C0_C0C0_79A4, 9, 24'h0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_sel", 32'(sel0), 32'h3F);
    chk("mid_rst_seg", 32'(seg0), 32'hFF);
    chk("mid_rst_fs", 32'(fs0), 32'h0);
    rst = 1'b0;
    idle3();
    run_frame(1, 6, 48'hFFFF_FFFF_79A4, 48'hC0C0_C0C0_79A4, 9, 24'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
